// File: rtl/alu_operand_stage.sv
// Operand-fetch stage feeding the 8-bit ALU: register file with write-back
// bypass, plus a single-entry valid/ready slot holding in1/in2/alu_ctrl/out_rd.
module alu_operand_stage #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 8,
  parameter int CTRL_W = 4,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [AW-1:0]     rs1,
  input  logic [AW-1:0]     rs2,
  input  logic [AW-1:0]     rd,
  input  logic [DATA_W-1:0] imm,
  input  logic              use_imm,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] in1,
  output logic [DATA_W-1:0] in2,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic [AW-1:0]     out_rd
);

  logic [DATA_W-1:0] regFile_q [NREGS];

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] in1_q, in1_d;
  logic [DATA_W-1:0] in2_q, in2_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [AW-1:0]     rd_q, rd_d;

  logic              wbLive;
  logic [DATA_W-1:0] readData1, readData2, operand2;
  logic              accept;

  // Writes land independently of flush and stall; x0 is never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regFile_q[i] <= '0;
      end
    end else if (wbLive) begin
      regFile_q[wb_addr] <= wb_data;
    end
  end

  assign wbLive = wb_en && (wb_addr != '0);

  always_comb begin
    readData1 = '0;
    readData2 = '0;
    if (rs1 != '0) begin
      readData1 = (wbLive && (wb_addr == rs1)) ? wb_data : regFile_q[rs1];
    end
    if (rs2 != '0) begin
      readData2 = (wbLive && (wb_addr == rs2)) ? wb_data : regFile_q[rs2];
    end
  end

  assign operand2 = use_imm ? imm : readData2;
  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  // Flush beats accept; data registers only change when a new instruction loads.
  always_comb begin
    valid_d = valid_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
    ctrl_d  = ctrl_q;
    rd_d    = rd_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      in1_d   = readData1;
      in2_d   = operand2;
      ctrl_d  = ctrl_in;
      rd_d    = rd;
    end else if (out_ready && valid_q) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      in1_q   <= '0;
      in2_q   <= '0;
      ctrl_q  <= '0;
      rd_q    <= '0;
    end else begin
      valid_q <= valid_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      ctrl_q  <= ctrl_d;
      rd_q    <= rd_d;
    end
  end

  assign out_valid = valid_q;
  assign in1       = in1_q;
  assign in2       = in2_q;
  assign alu_ctrl  = ctrl_q;
  assign out_rd    = rd_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: vector table for operand selection and
// bypass, hand-written sequences for stall, flush and asynchronous reset.
module tb_alu_operand_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] rs1, rs2, rd;
  logic [7:0] imm;
  logic       use_imm;
  logic [3:0] ctrl_in;
  logic       wb_en;
  logic [2:0] wb_addr;
  logic [7:0] wb_data;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] in1, in2;
  logic [3:0] alu_ctrl;
  logic [2:0] out_rd;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] rs1, rs2, rd;
    logic [7:0] imm;
    logic       useImm;
    logic [3:0] ctrl;
    logic       wbEn;
    logic [2:0] wbAddr;
    logic [7:0] wbData;
    logic [7:0] expIn1, expIn2;
  } vec_t;

  vec_t vecs [8];

  alu_operand_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .use_imm(use_imm), .ctrl_in(ctrl_in),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .in1(in1), .in2(in2), .alu_ctrl(alu_ctrl), .out_rd(out_rd)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] a1, input logic [2:0] a2,
                               input logic [2:0] d, input logic [7:0] im, input logic ui,
                               input logic [3:0] c);
    in_valid = v;
    rs1      = a1;
    rs2      = a2;
    rd       = d;
    imm      = im;
    use_imm  = ui;
    ctrl_in  = c;
  endtask

  task automatic writeBack(input logic en, input logic [2:0] a, input logic [7:0] dat);
    wb_en   = en;
    wb_addr = a;
    wb_data = dat;
  endtask

  task automatic checkSlot(input string tag, input logic v, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [3:0] ec, input logic [2:0] er);
    checkOutput({tag, ".out_valid"}, 32'(out_valid), 32'(v));
    checkOutput({tag, ".in1"},       32'(in1),       32'(e1));
    checkOutput({tag, ".in2"},       32'(in2),       32'(e2));
    checkOutput({tag, ".alu_ctrl"},  32'(alu_ctrl),  32'(ec));
    checkOutput({tag, ".out_rd"},    32'(out_rd),    32'(er));
  endtask

  initial begin
    //             rs1   rs2   rd    imm    ui    ctrl  wbEn  wbAddr wbData exp1   exp2
    vecs[0] = '{3'd1, 3'd2, 3'd4, 8'h00, 1'b0, 4'h0, 1'b0, 3'd0, 8'h00, 8'h05, 8'h06};
    vecs[1] = '{3'd3, 3'd1, 3'd3, 8'h00, 1'b0, 4'h1, 1'b1, 3'd3, 8'h2A, 8'h2A, 8'h05};
    vecs[2] = '{3'd3, 3'd3, 3'd2, 8'h00, 1'b0, 4'h2, 1'b0, 3'd0, 8'h00, 8'h2A, 8'h2A};
    vecs[3] = '{3'd0, 3'd4, 3'd5, 8'h11, 1'b1, 4'h3, 1'b1, 3'd0, 8'hFF, 8'h00, 8'h11};
    vecs[4] = '{3'd0, 3'd0, 3'd1, 8'h00, 1'b0, 4'h4, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00};
    vecs[5] = '{3'd2, 3'd1, 3'd7, 8'h00, 1'b0, 4'hF, 1'b1, 3'd2, 8'h77, 8'h77, 8'h05};
    vecs[6] = '{3'd1, 3'd2, 3'd0, 8'h00, 1'b0, 4'h5, 1'b1, 3'd1, 8'h99, 8'h99, 8'h77};
    vecs[7] = '{3'd1, 3'd7, 3'd6, 8'h80, 1'b1, 4'hA, 1'b1, 3'd7, 8'h33, 8'h99, 8'h80};

    rst       = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b1;
    applyStimulus(1'b0, 3'd0, 3'd0, 3'd0, 8'h00, 1'b0, 4'h0);
    writeBack(1'b0, 3'd0, 8'h00);
    #2;
    checkSlot("reset", 1'b0, 8'h00, 8'h00, 4'h0, 3'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    checkOutput("reset.in_ready", 32'(in_ready), 32'd1);

    writeBack(1'b1, 3'd1, 8'h05);
    tick();
    writeBack(1'b1, 3'd2, 8'h06);
    tick();
    writeBack(1'b0, 3'd0, 8'h00);

    // Back-to-back accepts with out_ready held high.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].imm, vecs[i].useImm, vecs[i].ctrl);
      writeBack(vecs[i].wbEn, vecs[i].wbAddr, vecs[i].wbData);
      #1;
      checkOutput($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'd1);
      tick();
      checkSlot($sformatf("vec%0d", i), 1'b1, vecs[i].expIn1, vecs[i].expIn2, vecs[i].ctrl, vecs[i].rd);
    end

    // Stall: a different instruction waits, and R1 is rewritten meanwhile.
    out_ready = 1'b0;
    applyStimulus(1'b1, 3'd2, 3'd2, 3'd1, 8'h00, 1'b0, 4'hC);
    writeBack(1'b1, 3'd1, 8'h44);
    #1;
    checkOutput("stall.in_ready0", 32'(in_ready), 32'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      writeBack(1'b0, 3'd0, 8'h00);
      checkSlot($sformatf("stall%0d", c), 1'b1, 8'h99, 8'h80, 4'hA, 3'd6);
      checkOutput($sformatf("stall%0d.in_ready", c), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    applyStimulus(1'b1, 3'd1, 3'd2, 3'd2, 8'h00, 1'b0, 4'h9);
    #1;
    checkOutput("release.in_ready", 32'(in_ready), 32'd1);
    tick();
    checkSlot("release", 1'b1, 8'h44, 8'h77, 4'h9, 3'd2);

    // Flush with a valid input and a write-back in the same cycle.
    out_ready = 1'b0;
    flush     = 1'b1;
    applyStimulus(1'b1, 3'd5, 3'd0, 3'd7, 8'h00, 1'b0, 4'hB);
    writeBack(1'b1, 3'd5, 8'h5C);
    tick();
    flush = 1'b0;
    writeBack(1'b0, 3'd0, 8'h00);
    checkSlot("flush", 1'b0, 8'h44, 8'h77, 4'h9, 3'd2);
    out_ready = 1'b1;
    applyStimulus(1'b1, 3'd5, 3'd5, 3'd3, 8'h00, 1'b0, 4'h6);
    tick();
    checkSlot("postflush", 1'b1, 8'h5C, 8'h5C, 4'h6, 3'd3);

    // Asynchronous reset while stalled.
    out_ready = 1'b0;
    applyStimulus(1'b0, 3'd0, 3'd0, 3'd0, 8'h00, 1'b0, 4'h0);
    tick();
    checkOutput("prereset.out_valid", 32'(out_valid), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    checkSlot("asyncreset", 1'b0, 8'h00, 8'h00, 4'h0, 3'd0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    applyStimulus(1'b1, 3'd1, 3'd2, 3'd4, 8'h00, 1'b0, 4'h7);
    #1;
    checkOutput("postreset.in_ready", 32'(in_ready), 32'd1);
    tick();
    checkSlot("postreset", 1'b1, 8'h00, 8'h00, 4'h7, 3'd4);
    applyStimulus(1'b0, 3'd0, 3'd0, 3'd0, 8'h00, 1'b0, 4'h0);
    tick();
    checkOutput("drain.out_valid", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Operand-fetch stage directly upstream of the 8-bit ALU. Holds the register file (x0 hardwired to zero) and drives the ALU's `in1`, `in2` and `alu_ctrl` from a registered pipeline slot. The slot uses a valid/ready handshake and supports write-back bypass and flush. Register-file writes come from the write-back stage downstream of the ALU.

## Interface
- `DATA_W`, default 8: datapath width; matches the ALU operand width.
- `NREGS`, default 8: number of architectural registers; address width is `$clog2(NREGS)` (3 at default).
- `CTRL_W`, default 4: ALU control width; matches the ALU `alu_ctrl` width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  decoded instruction present.
- `in_ready`  out  1  stage can accept this cycle.
- `rs1`, `rs2`, `rd`  in  3  source and destination register addresses.
- `imm`  in  DATA_W  immediate operand.
- `use_imm`  in  1  1: `in2` takes `imm`; 0: `in2` takes R[rs2].
- `ctrl_in`  in  CTRL_W  ALU operation code, passed through unchanged.
- `wb_en`  in  1  register-file write enable.
- `wb_addr`  in  3  write address.
- `wb_data`  in  DATA_W  write data.
- `flush`  in  1  discard the held slot and any incoming instruction.
- `out_valid`  out  1  ALU operands valid.
- `out_ready`  in  1  ALU/execute side consumes this cycle.
- `in1`, `in2`  out  DATA_W  ALU operands.
- `alu_ctrl`  out  CTRL_W  ALU operation.
- `out_rd`  out  3  destination register, forwarded to write-back.

## Operation
- Register file:
  - NREGS×DATA_W with 2 combinational read ports and 1 synchronous write port.
  - Writes to address 0 are ignored.
  - Reads of address 0 return 0.
- Write-back bypass:
  - Applies when `wb_en`=1, `wb_addr`≠0 and `wb_addr` equals `rs1` (or `rs2`) in the same cycle.
  - The matching read uses `wb_data`, not the stale array value.
- Operand selection:
  - `in1` ← R[rs1], bypassed as above.
  - `in2` ← `imm` if `use_imm`, else R[rs2], bypassed as above.
- Accept condition: accept = `in_valid` & `in_ready` & !`flush`.
- `in_ready` = !`out_valid` | `out_ready`. This is combinational, giving a full-throughput single-entry slot.
- Slot update each rising edge, in priority order:
  1. `flush`: `out_valid`←0, data registers unchanged.
  2. Accept: `out_valid`←1, and `in1`/`in2`/`alu_ctrl`/`out_rd` load the selected values.
  3. `out_ready` & `out_valid` without accept: `out_valid`←0.
  4. Otherwise: hold all outputs.
- Stall: while `out_valid`=1 and `out_ready`=0, all slot outputs are held stable.
  - Register writes during a stall do not alter the held operands; capture happens at accept only.
- The register-file write occurs regardless of `flush` or stall state.

## Timing
- Reset (asynchronous, immediate):
  - `out_valid`=0; `in1`=`in2`=0; `alu_ctrl`=0; `out_rd`=0.
  - All register-file entries are 0.
  - `in_ready`=1 once `rst` is deasserted.
- Latency: an instruction accepted at edge N presents its operands with `out_valid`=1 from just after edge N.
  - Throughput: 1 instruction per cycle when `out_ready`=1.
- Write visibility:
  - A write at edge N is visible to array reads after N.
  - Through the bypass, the written value is already visible in the cycle before edge N (same-cycle read-after-write).
- Simultaneous flush and accept: flush wins; the instruction is dropped and `out_valid`=0 next cycle.
- Reset asserted mid-stall: the slot is cleared and register contents are lost; no output is held over.

## Test plan
- Reset, then write R1=5 and R2=6.
  - Issue rs1=1, rs2=2, ctrl=0000, use_imm=0.
  - Required: one cycle later `out_valid`=1, `in1`=0x05, `in2`=0x06, `alu_ctrl`=0000.
- Same-cycle bypass: `wb_en`=1, `wb_addr`=3, `wb_data`=0x2A together with an accept of rs1=3.
  - Required: `in1`=0x2A. A follow-up read of R3 also returns 0x2A.
- x0 behaviour: write `wb_addr`=0 with 0xFF, then issue rs1=0 with use_imm=1, imm=0x11.
  - Required: `in1`=0x00, `in2`=0x11.
- Stall: hold `out_ready`=0 for 3 cycles with `in_valid`=1 and a different instruction on the inputs.
  - Required: outputs unchanged and `in_ready`=0 throughout.
  - Releasing the stall accepts the next instruction on the same edge as the handoff.
- Flush with `in_valid`=1 asserted in the same cycle.
  - Required: `out_valid`=0 next cycle.
  - A write-back in that same cycle is still committed; verify by a later read.
- Assert `rst` asynchronously mid-stall.
  - Required: `out_valid` drops to 0 before the next clock edge; R1 and R2 read 0 afterwards.
